// File: rtl/store_pkg.sv
// Shared types and geometry for the latch-store write sequencer.
package store_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  localparam int STORE_ROWS = 3;
  localparam int STORE_COLS = 2;

  // Counter holds up to max(phase)-1, never narrower than one bit.
  function automatic int phase_cnt_w(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/store_phase_cnt.sv
// Loadable down-counter with zero flag; shared by setup, pulse and hold phases.
module store_phase_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/store_write_ctrl.sv
// Write sequencer for a row/column latch store: drives row data, then strobes
// one column (or all, for clear) through setup/pulse/hold phases.
module store_write_ctrl
  import store_pkg::*;
#(
  parameter int ROWS      = STORE_ROWS,
  parameter int COLS      = STORE_COLS,
  parameter int CW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_clr,
  input  logic [CW-1:0]   req_col,
  input  logic [ROWS-1:0] req_data,
  output logic [ROWS-1:0] dat,
  output logic [COLS-1:0] cap,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CNTW = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

  state_e          state, state_n;
  logic [CW-1:0]   col_q, col_n;
  logic            clr_q, clr_n;
  logic [ROWS-1:0] dat_n;
  logic [COLS-1:0] cap_n, mask;
  logic            done_n, err_n;
  logic            cnt_load, cnt_zero;
  logic [CNTW-1:0] cnt_val;
  logic            accept, oor;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign oor       = !req_clr && ({1'b0, req_col} >= COLS_L);
  assign mask      = clr_q ? '1 : (COLS'(1) << col_q);

  store_phase_cnt #(.W(CNTW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    col_n    = col_q;
    clr_n    = clr_q;
    dat_n    = dat;
    cap_n    = '0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: if (accept) begin
        if (oor) begin
          // Bad column: report and stay idle without touching the array.
          done_n = 1'b1;
          err_n  = 1'b1;
        end else begin
          col_n    = req_col;
          clr_n    = req_clr;
          dat_n    = req_clr ? '0 : req_data;
          state_n  = SETUP;
          cnt_load = 1'b1;
          cnt_val  = CNTW'(SETUP_CYC - 1);
        end
      end
      SETUP: if (cnt_zero) begin
        state_n  = PULSE;
        cap_n    = mask;
        cnt_load = 1'b1;
        cnt_val  = CNTW'(PULSE_CYC - 1);
      end
      PULSE: begin
        // cap is registered, so it is raised/dropped on the edges entering/leaving PULSE.
        if (cnt_zero) begin
          state_n  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = CNTW'(HOLD_CYC - 1);
        end else begin
          cap_n = mask;
        end
      end
      HOLD: if (cnt_zero) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col_q <= '0;
      clr_q <= 1'b0;
      dat   <= '0;
      cap   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      col_q <= col_n;
      clr_q <= clr_n;
      dat   <= dat_n;
      cap   <= cap_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_store_write_ctrl.sv
// Bench for store_write_ctrl: two instances (1/1/1 and 2/3/2 phases) sharing stimulus.
module tb_store_write_ctrl;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [1:0] cap;
    logic [2:0] dat;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    logic            clr;
    logic [1:0]      col;
    logic [2:0]      data;
    logic            exp_err;
    logic [1:0]      exp_mask;
    logic [2:0]      exp_dat;
    logic [1:0][2:0] exp_lat;
  } vec_t;

  logic       clk = 0, rst = 1;
  logic       req_valid = 0, req_clr = 0;
  logic [1:0] req_col = 0;
  logic [2:0] req_data = 0;
  logic       ready_a, busy_a, done_a, err_a, ready_b, busy_b, done_b, err_b;
  logic [2:0] dat_a, dat_b;
  logic [1:0] cap_a, cap_b;
  obs_t       oa, ob;
  logic [1:0][2:0] lat_a = '0, lat_b = '0, mem_a = '0, mem_b = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  store_write_ctrl u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_clr(req_clr),
    .req_col(req_col), .req_data(req_data), .dat(dat_a), .cap(cap_a), .busy(busy_a),
    .done(done_a), .err(err_a));

  store_write_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_clr(req_clr),
    .req_col(req_col), .req_data(req_data), .dat(dat_b), .cap(cap_b), .busy(busy_b),
    .done(done_b), .err(err_b));

  assign oa = {ready_a, busy_a, cap_a, dat_a, done_a, err_a};
  assign ob = {ready_b, busy_b, cap_b, dat_b, done_b, err_b};

  // Level-sensitive latch array behind each instance.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (cap_a[c]) lat_a[c] <= dat_a;
      if (cap_b[c]) lat_b[c] <= dat_b;
    end
  end

  // Expected outputs k cycles after the accept cycle, from the phase lengths alone.
  function automatic obs_t exp_out(input int k, input int s, input int p, input int h,
                                   input logic e, input logic [1:0] m, input logic [2:0] d);
    obs_t o;
    o.dat = d;
    if (e) begin
      o.ready = 1'b1; o.busy = 1'b0; o.cap = 2'b00;
      o.done = (k == 1); o.err = (k == 1);
    end else begin
      o.busy  = (k <= s + p + h);
      o.ready = !o.busy;
      o.cap   = (k > s && k <= s + p) ? m : 2'b00;
      o.done  = (k == s + p + h + 1);
      o.err   = 1'b0;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, expv);
    end
  endtask

  // Issue one request on both instances and follow it for 10 cycles.
  task automatic run_req(input string tag, input logic clr, input logic [1:0] col,
                         input logic [2:0] data, input logic e, input logic [1:0] m,
                         input logic [2:0] d);
    req_valid = 1; req_clr = clr; req_col = col; req_data = data;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 0;
      chk($sformatf("%s_a_k%0d", tag, k), oa, exp_out(k, 1, 1, 1, e, m, d));
      chk($sformatf("%s_b_k%0d", tag, k), ob, exp_out(k, 2, 3, 2, e, m, d));
    end
  endtask

  vec_t tbl [7];
  obs_t idle_o;
  logic [2:0] datm;

  initial begin
    tbl[0] = '{1'b0, 2'd1, 3'b101, 1'b0, 2'b10, 3'b101, 6'b101_000};
    tbl[1] = '{1'b0, 2'd0, 3'b111, 1'b0, 2'b01, 3'b111, 6'b101_111};
    tbl[2] = '{1'b0, 2'd1, 3'b111, 1'b0, 2'b10, 3'b111, 6'b111_111};
    tbl[3] = '{1'b1, 2'd0, 3'b110, 1'b0, 2'b11, 3'b000, 6'b000_000};
    tbl[4] = '{1'b0, 2'd2, 3'b111, 1'b1, 2'b00, 3'b000, 6'b000_000};
    tbl[5] = '{1'b0, 2'd3, 3'b101, 1'b1, 2'b00, 3'b000, 6'b000_000};
    tbl[6] = '{1'b0, 2'd0, 3'b010, 1'b0, 2'b01, 3'b010, 6'b000_010};
    idle_o = '{ready:1'b1, busy:1'b0, cap:2'b00, dat:3'b000, done:1'b0, err:1'b0};

    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_a", oa, idle_o);
    chk("reset_b", ob, idle_o);

    for (int i = 0; i < 7; i++) begin
      run_req($sformatf("tbl%0d", i), tbl[i].clr, tbl[i].col, tbl[i].data,
              tbl[i].exp_err, tbl[i].exp_mask, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_lat_a", i), {3'b0, lat_a}, {3'b0, tbl[i].exp_lat});
      chk($sformatf("tbl%0d_lat_b", i), {3'b0, lat_b}, {3'b0, tbl[i].exp_lat});
    end
    mem_a = tbl[6].exp_lat;
    mem_b = tbl[6].exp_lat;

    // Back-to-back: second request presented while busy, accepted on the done cycle.
    req_valid = 1; req_clr = 0; req_col = 0; req_data = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 4) chk($sformatf("b2b_a_k%0d", k), oa, exp_out(k, 1, 1, 1, 0, 2'b01, 3'b011));
      else        chk($sformatf("b2b_a_k%0d", k), oa, exp_out(k - 4, 1, 1, 1, 0, 2'b10, 3'b110));
      chk($sformatf("b2b_b_k%0d", k), ob, exp_out(k, 2, 3, 2, 0, 2'b01, 3'b011));
      if (k == 1) begin req_col = 1; req_data = 3'b110; end
      if (k == 5) req_valid = 0;
    end
    mem_a = {3'b110, 3'b011};
    mem_b[0] = 3'b011;
    chk("b2b_lat_a", {3'b0, lat_a}, {3'b0, mem_a});
    chk("b2b_lat_b", {3'b0, lat_b}, {3'b0, mem_b});

    // Reset while instance a is pulsing: abandoned, no done.
    req_valid = 1; req_clr = 0; req_col = 0; req_data = 3'b100;
    @(negedge clk);
    req_valid = 0;
    chk("rstp_a_k1", oa, exp_out(1, 1, 1, 1, 0, 2'b01, 3'b100));
    @(negedge clk);
    chk("rstp_a_k2", oa, exp_out(2, 1, 1, 1, 0, 2'b01, 3'b100));
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstp_a_after", oa, idle_o);
    chk("rstp_b_after", ob, idle_o);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rstp_a_quiet%0d", k), oa, idle_o);
      chk($sformatf("rstp_b_quiet%0d", k), ob, idle_o);
    end
    run_req("rstp_rewr", 0, 2'd0, 3'b001, 0, 2'b01, 3'b001);
    mem_a[0] = 3'b001;
    mem_b[0] = 3'b001;
    chk("rstp_lat_a", {3'b0, lat_a}, {3'b0, mem_a});
    chk("rstp_lat_b", {3'b0, lat_b}, {3'b0, mem_b});
    datm = 3'b001;

    // Random requests against the store model.
    for (int i = 0; i < 40; i++) begin
      logic       c, e;
      logic [1:0] col, m;
      logic [2:0] d, nd;
      c   = ($urandom % 6) == 0;
      col = 2'($urandom % 4);
      d   = 3'($urandom);
      e   = !c && (col >= 2);
      m   = c ? 2'b11 : (e ? 2'b00 : (2'b01 << col));
      nd  = e ? datm : (c ? 3'b000 : d);
      run_req($sformatf("rnd%0d", i), c, col, d, e, m, nd);
      datm = nd;
      if (c) begin
        mem_a = '0; mem_b = '0;
      end else if (!e) begin
        mem_a[col[0]] = d; mem_b[col[0]] = d;
      end
      chk($sformatf("rnd%0d_lat_a", i), {3'b0, lat_a}, {3'b0, mem_a});
      chk($sformatf("rnd%0d_lat_b", i), {3'b0, lat_b}, {3'b0, mem_b});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
